// File: rtl/muon_interval_timer.sv
// -----------------------------------------------------------------------------
// muon_interval_timer
//
// Measures the number of clk cycles between a start pulse (muon arrival) and a
// stop pulse (decay electron). The result is offered downstream over a
// valid/ready handshake. Measurements that run to TIMEOUT_CYCLES without a
// stop are either reported with a timeout flag or dropped silently. Each
// measurement is followed by an optional dead time. Start pulses that arrive
// while the block is busy are tallied in a saturating counter.
//
// Ports
//   clk             : system clock
//   rst             : synchronous, active-high reset
//   enable          : allows arming on a start edge while idle
//   start           : level input; a rising edge begins a measurement
//   stop            : level input; a rising edge ends a measurement
//   result_valid    : a result is held on result_interval/result_timeout
//   result_ready    : downstream accepts the result
//   result_interval : measured interval in cycles
//   result_timeout  : no stop arrived within TIMEOUT_CYCLES
//   busy            : high in every state except IDLE
//   missed_count    : start edges rejected while busy (saturating)
// -----------------------------------------------------------------------------
module muon_interval_timer #(
  parameter int unsigned WIDTH           = 32,
  parameter int unsigned TIMEOUT_CYCLES  = 5_000_000,
  parameter int unsigned DEAD_CYCLES     = 16,
  parameter bit          REPORT_TIMEOUTS = 1'b1,
  parameter int unsigned MISS_WIDTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  start,
  input  logic                  stop,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic [WIDTH-1:0]      result_interval,
  output logic                  result_timeout,
  output logic                  busy,
  output logic [MISS_WIDTH-1:0] missed_count
);

  // Dead-time counter needs at least one bit even when dead time is disabled.
  localparam int unsigned DW = (DEAD_CYCLES > 32'd1) ? $clog2(DEAD_CYCLES + 32'd1) : 32'd1;

  localparam logic [WIDTH-1:0]      TIMEOUT_W  = WIDTH'(TIMEOUT_CYCLES);
  localparam logic [DW-1:0]         DEAD_W     = DW'(DEAD_CYCLES);
  localparam logic [MISS_WIDTH-1:0] MISS_MAX   = {MISS_WIDTH{1'b1}};
  localparam bit                    HAS_DEAD   = (DEAD_CYCLES != 32'd0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COUNT  = 2'd1,
    ST_REPORT = 2'd2,
    ST_DEAD   = 2'd3
  } state_e;

  state_e                  state_q;
  logic                    busy_q;
  logic [WIDTH-1:0]        count_q;
  logic [DW-1:0]           dcount_q;
  logic                    valid_q;
  logic [WIDTH-1:0]        interval_q;
  logic                    timeout_q;
  logic                    start_q;
  logic                    stop_q;
  logic [MISS_WIDTH-1:0]   missed_q;
  logic [MISS_WIDTH-1:0]   missed_d;
  logic                    start_edge_s;
  logic                    stop_edge_s;

  assign start_edge_s = start & ~start_q;
  assign stop_edge_s  = stop & ~stop_q;

  // Next missed-start count: any start edge outside IDLE, held at full scale.
  always_comb begin
    missed_d = missed_q;
    if (start_edge_s && (state_q != ST_IDLE) && (missed_q != MISS_MAX)) begin
      missed_d = missed_q + MISS_WIDTH'(1);
    end else begin
      missed_d = missed_q;
    end
  end

  // Measurement FSM with its registered outputs and input edge history.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      count_q    <= {WIDTH{1'b0}};
      dcount_q   <= {DW{1'b0}};
      valid_q    <= 1'b0;
      interval_q <= {WIDTH{1'b0}};
      timeout_q  <= 1'b0;
      // History starts high so a line held high through reset shows no edge.
      start_q    <= 1'b1;
      stop_q     <= 1'b1;
      missed_q   <= {MISS_WIDTH{1'b0}};
    end else begin
      start_q  <= start;
      stop_q   <= stop;
      missed_q <= missed_d;
      case (state_q)
        ST_IDLE: begin
          // Start wins over a simultaneous stop; a lone stop is ignored.
          if (start_edge_s && enable) begin
            count_q <= WIDTH'(1);
            state_q <= ST_COUNT;
            busy_q  <= 1'b1;
          end
        end
        ST_COUNT: begin
          // A stop on the final count is still a genuine stop.
          if (stop_edge_s) begin
            interval_q <= count_q;
            timeout_q  <= 1'b0;
            valid_q    <= 1'b1;
            state_q    <= ST_REPORT;
          end else if (count_q == TIMEOUT_W) begin
            interval_q <= TIMEOUT_W;
            timeout_q  <= 1'b1;
            if (REPORT_TIMEOUTS) begin
              valid_q <= 1'b1;
              state_q <= ST_REPORT;
            end else if (HAS_DEAD) begin
              dcount_q <= DEAD_W;
              state_q  <= ST_DEAD;
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            count_q <= count_q + WIDTH'(1);
          end
        end
        ST_REPORT: begin
          // valid_q is always high here, so ready alone completes the transfer.
          if (result_ready) begin
            valid_q <= 1'b0;
            if (HAS_DEAD) begin
              dcount_q <= DEAD_W;
              state_q  <= ST_DEAD;
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        ST_DEAD: begin
          if (dcount_q == DW'(1)) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            dcount_q <= dcount_q - DW'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign result_valid    = valid_q;
  assign result_interval = interval_q;
  assign result_timeout  = timeout_q;
  assign busy            = busy_q;
  assign missed_count    = missed_q;

endmodule
